// File: rtl/spi_ram_ctrl.sv
// SPI-slave front end for the single-port RAM: frames MOSI into {cmd,payload} words and
// serialises read data onto MISO. Optional SPI_FRAME_ERR_EN adds a frame_err abort pulse.
module spi_ram_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TXC_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FRAME_W);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [FRAME_W-2:0] rx_sh_r;
    logic [FRAME_W-1:0] rx_data_r;
    logic               rx_valid_r;
    logic               rd_addr_done_r;
    logic               wait_tx_r;
    logic [DATA_W-1:0]  tx_sh_r;
    logic [TXC_W-1:0]   tx_left_r;
    logic               shifting_r;
    logic               miso_r;

    logic               in_frame_s;
    logic               last_bit_s;
    logic               tx_load_s;

    assign in_frame_s = (state_r == WRITE) || (state_r == READ_ADD) || (state_r == READ_DATA);
    assign last_bit_s = in_frame_s && !SS_n && (cnt_r == CNT_LAST);
    // tx_valid is ignored during the strobe cycle so a level left over from the previous read is not taken
    assign tx_load_s  = wait_tx_r && tx_valid && !rx_valid_r;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; the command MSB and read-address history pick the frame type
    always_comb begin
        state_nxt_s = state_r;
        if (SS_n) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: state_nxt_s = CHK_CMD;
                CHK_CMD: begin
                    if (!MOSI) begin
                        state_nxt_s = WRITE;
                    end else if (rd_addr_done_r) begin
                        state_nxt_s = READ_DATA;
                    end else begin
                        state_nxt_s = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: state_nxt_s = state_r;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Receive shifter, frame strobe and read-address ordering flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r          <= {CNT_W{1'b0}};
            rx_sh_r        <= {(FRAME_W-1){1'b0}};
            rx_data_r      <= {FRAME_W{1'b0}};
            rx_valid_r     <= 1'b0;
            rd_addr_done_r <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            if (SS_n) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == CHK_CMD) begin
                rx_sh_r <= {rx_sh_r[FRAME_W-3:0], MOSI};
                cnt_r   <= CNT_W'(1);
            end else if (last_bit_s) begin
                rx_data_r  <= {rx_sh_r, MOSI};
                rx_valid_r <= 1'b1;
                cnt_r      <= CNT_DONE;
                if (state_r == READ_ADD) begin
                    rd_addr_done_r <= 1'b1;
                end else if (state_r == READ_DATA) begin
                    rd_addr_done_r <= 1'b0;
                end
            end else if (in_frame_s && (cnt_r < CNT_LAST)) begin
                rx_sh_r <= {rx_sh_r[FRAME_W-3:0], MOSI};
                cnt_r   <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Read-data response: wait for RAM data, then shift it out MSB first
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_tx_r  <= 1'b0;
            tx_sh_r    <= {DATA_W{1'b0}};
            tx_left_r  <= {TXC_W{1'b0}};
            shifting_r <= 1'b0;
            miso_r     <= 1'b0;
        end else if (SS_n) begin
            wait_tx_r  <= 1'b0;
            tx_sh_r    <= {DATA_W{1'b0}};
            tx_left_r  <= {TXC_W{1'b0}};
            shifting_r <= 1'b0;
            miso_r     <= 1'b0;
        end else begin
            if (last_bit_s && (state_r == READ_DATA)) begin
                wait_tx_r <= 1'b1;
            end
            if (tx_load_s) begin
                wait_tx_r  <= 1'b0;
                miso_r     <= tx_data[DATA_W-1];
                tx_sh_r    <= {tx_data[DATA_W-2:0], 1'b0};
                tx_left_r  <= TXC_W'(DATA_W - 1);
                shifting_r <= 1'b1;
            end else if (shifting_r) begin
                if (tx_left_r != {TXC_W{1'b0}}) begin
                    miso_r    <= tx_sh_r[DATA_W-1];
                    tx_sh_r   <= {tx_sh_r[DATA_W-2:0], 1'b0};
                    tx_left_r <= tx_left_r - TXC_W'(1);
                end else begin
                    miso_r     <= 1'b0;
                    shifting_r <= 1'b0;
                end
            end
        end
    end

    assign MISO     = miso_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;

`ifdef SPI_FRAME_ERR_EN
    logic frame_err_r;

    // Pulses when SS_n rises on a partial frame or an unfinished read-data response
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= SS_n &&
                ((in_frame_s && (cnt_r != {CNT_W{1'b0}}) && (cnt_r != CNT_DONE)) ||
                 wait_tx_r ||
                 (shifting_r && (tx_left_r != {TXC_W{1'b0}})));
        end
    end

    assign frame_err = frame_err_r;
`endif

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: window-position reference model, RAM responder,
// directed scenarios with literal expectations, then randomized frames.
module tb_spi_ram_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         SS_n = 1'b1;
    logic         MOSI = 1'b0;
    logic         MISO;
    logic [W+1:0] rx_data;
    logic         rx_valid;
    logic [W-1:0] tx_data;
    logic         tx_valid;

    int tests = 0;
    int fails = 0;

    spi_ram_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .rstn(rstn), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_pos counts consecutive SS_n-low cycles; positions 1..10 carry frame bits
    int       m_pos = 0;
    logic [9:0] m_bits = 10'd0;
    int       m_kind = 0;          // 0 write, 1 read address, 2 read data
    bit       m_rd_done = 1'b0;
    bit       m_rxv = 1'b0;
    logic [9:0] m_rxd = 10'd0;
    bit       m_wait = 1'b0;
    bit       m_miso = 1'b0;
    bit       m_load;
    bit       m_q[$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pos = 0; m_bits = 10'd0; m_kind = 0; m_rd_done = 1'b0; m_rxv = 1'b0;
            m_rxd = 10'd0; m_wait = 1'b0; m_miso = 1'b0; m_q.delete();
        end else if (SS_n) begin
            m_pos = 0; m_wait = 1'b0; m_q.delete(); m_miso = 1'b0; m_rxv = 1'b0;
        end else begin
            m_load = m_wait && (tx_valid === 1'b1) && !m_rxv;
            m_rxv = 1'b0;
            if (m_pos >= 1 && m_pos <= 10) begin
                m_bits = {m_bits[8:0], MOSI};
                if (m_pos == 1) m_kind = !MOSI ? 0 : (m_rd_done ? 2 : 1);
                if (m_pos == 10) begin
                    m_rxv = 1'b1;
                    m_rxd = m_bits;
                    if (m_kind == 1) m_rd_done = 1'b1;
                    if (m_kind == 2) begin
                        m_rd_done = 1'b0;
                        m_wait = 1'b1;
                    end
                end
            end
            if (m_load) begin
                m_wait = 1'b0;
                for (int i = W - 1; i >= 0; i--) m_q.push_back(tx_data[i]);
            end
            m_miso = (m_q.size() > 0) ? m_q.pop_front() : 1'b0;
            if (m_pos < 1000) m_pos++;
        end
    end

    // Compare process: every cycle, sampled on the falling edge
    int         strobes = 0;
    logic [9:0] last_rx = 10'd0;
    always @(negedge clk) begin
        check("rx_valid", rx_valid, m_rxv);
        check("rx_data", rx_data, m_rxd);
        check("MISO", MISO, m_miso);
        if (rx_valid === 1'b1) begin
            strobes++;
            last_rx = rx_data;
        end
    end

    // RAM responder: decodes commands, answers a read-data strobe after 1+delay cycles
    logic [7:0] mem [256];
    logic [7:0] wa = 8'd0;
    logic [7:0] ra = 8'd0;
    int ram_cd = 0;
    bit ram_clr = 1'b0;
    int ram_dly_max = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            tx_valid = 1'b0; ram_cd = 0; ram_clr = 1'b0;
        end else begin
            if (ram_cd > 0) begin
                ram_cd--;
                if (ram_cd == 0) begin
                    tx_valid = 1'b1;
                    tx_data = mem[ra];
                end else begin
                    tx_valid = 1'b0;
                    tx_data = 8'($urandom);
                end
            end
            if (ram_clr) begin
                tx_valid = 1'b0;
                tx_data = 8'($urandom);
                ram_clr = 1'b0;
            end
            if (rx_valid === 1'b1) begin
                case (rx_data[9:8])
                    2'd0: wa = rx_data[7:0];
                    2'd1: mem[wa] = rx_data[7:0];
                    2'd2: ra = rx_data[7:0];
                    default: ram_cd = 1 + int'($urandom_range(0, ram_dly_max));
                endcase
                if (rx_data[9:8] != 2'd3) ram_clr = 1'b1;
            end
        end
    end

    // MISO samples per window cycle; index k is the value seen at the k-th falling edge
    bit mq[$];

    task automatic send(input logic [9:0] f, input int nbits, input int extra, input int gap,
                        input int rst_at);
        int total;
        total = 1 + nbits + extra;
        mq.delete();
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            mq.push_back(MISO);
            if (k == rst_at) begin
                #2;
                rstn = 1'b0;
                SS_n = 1'b1;
                #1;
                check("rst_async_miso", MISO, 32'd0);
                check("rst_async_rxv", rx_valid, 32'd0);
                @(negedge clk);
                @(negedge clk);
                #2 rstn = 1'b1;
                break;
            end
            SS_n = 1'b0;
            if (k >= 1 && k <= nbits) MOSI = f[10 - k];
            else MOSI = 1'($urandom);
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            mq.push_back(MISO);
            SS_n = 1'b1;
            MOSI = 1'($urandom);
        end
    endtask

    function automatic logic [7:0] miso_byte();
        logic [7:0] v;
        v = 8'd0;
        if (mq.size() > 20) begin
            for (int i = 13; i <= 20; i++) v = {v[6:0], mq[i]};
        end
        return v;
    endfunction

    function automatic logic [31:0] miso_any();
        logic [31:0] a;
        a = 32'd0;
        foreach (mq[i]) a = a | 32'(mq[i]);
        return a;
    endfunction

    int s0;
    logic [9:0] rf;
    int rnb, rex, rgap, rrst;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
        tx_data = 8'd0;
        ram_dly_max = 0;
        repeat (3) @(negedge clk);
        check("rst_miso", MISO, 32'd0);
        check("rst_rxv", rx_valid, 32'd0);
        check("rst_rxd", rx_data, 32'd0);
        #2 rstn = 1'b1;
        repeat (2) @(negedge clk);

        s0 = strobes;
        send(10'h02A, 10, 3, 1, -1);
        check("wr_addr_cnt", strobes - s0, 32'd1);
        check("wr_addr_data", last_rx, 32'h02A);

        s0 = strobes;
        send(10'h1C3, 10, 12, 1, -1);
        check("wr_data_cnt", strobes - s0, 32'd1);
        check("wr_data_data", last_rx, 32'h1C3);
        check("wr_data_miso", miso_any(), 32'd0);

        send(10'h22A, 10, 2, 1, -1);
        check("rd_addr_data", last_rx, 32'h22A);
        send(10'h300, 10, 14, 1, -1);
        check("rd_data_rx", last_rx, 32'h300);
        check("rd_data_miso", miso_byte(), 32'hC3);
        check("rd_data_tail", mq[21], 32'd0);

        send(10'h355, 10, 14, 1, -1);
        check("order_rx", last_rx, 32'h355);
        check("order_miso", miso_any(), 32'd0);
        send(10'h300, 10, 14, 1, -1);
        check("order_rd_miso", miso_byte(), 32'hC3);

        send(10'h255, 10, 1, 1, -1);
        s0 = strobes;
        send(10'h3FF, 5, 0, 2, -1);
        check("abort_cnt", strobes - s0, 32'd0);
        send(10'h300, 10, 14, 1, -1);
        check("abort_keep_miso", miso_byte(), 32'hAA);

        send(10'h22A, 10, 1, 1, -1);
        send(10'h300, 10, 14, 1, 13);
        send(10'h300, 10, 14, 1, -1);
        check("post_rst_miso", miso_any(), 32'd0);

        ram_dly_max = 3;
        for (int n = 0; n < 300; n++) begin
            rf   = 10'($urandom);
            rnb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : 10;
            rex  = (rnb == 10) ? int'($urandom_range(0, 16)) : 0;
            rgap = int'($urandom_range(1, 3));
            rrst = ($urandom_range(0, 40) == 0) ? int'($urandom_range(1, 20)) : -1;
            send(rf, rnb, rex, rgap, rrst);
        end
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
